match_round_controller: RTL

- Sequences a two-player match around the per-player movement datapaths: start countdown, fight, KO detection, pause, respawn, game over.
- Owns the gated frame tick that the movement FSMs consume, so it freezes both players outside FIGHT.
- Issues one-cycle respawn pulses into each player's movement reset.
- Tracks stocks and declares the winner. Sits between the top-level frame-rate strobe and the two player movement blocks.

---
 rtl/match_round_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/match_round_controller.sv
// Two-player match sequencer: countdown, fight, KO pause/respawn, stocks and winner.
// Optional SUDDEN_DEATH_EN: a double-KO draw replays as a fresh countdown at one stock each.
module match_round_controller #(
   parameter int STOCKS          = 3,
   parameter int SECOND_FRAMES   = 60,
   parameter int KO_PAUSE_FRAMES = 60,
   parameter int BLAST_X_MAX     = 639,
   parameter int BLAST_Y_MAX     = 479
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_rate,
   input  logic       start,
   input  logic [9:0] p1_x,
   input  logic [9:0] p1_y,
   input  logic [9:0] p2_x,
   input  logic [9:0] p2_y,
   output logic       move_tick,
   output logic       p1_respawn,
   output logic       p2_respawn,
   output logic [1:0] p1_stocks,
   output logic [1:0] p2_stocks,
   output logic [1:0] countdown,
   output logic [1:0] winner,
   output logic [2:0] round_state
);

   localparam int CNT_MAX = (SECOND_FRAMES > KO_PAUSE_FRAMES) ? SECOND_FRAMES : KO_PAUSE_FRAMES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] SEC_LOAD   = CNT_W'(SECOND_FRAMES - 1);
   localparam logic [CNT_W-1:0] KO_LOAD    = CNT_W'(KO_PAUSE_FRAMES - 1);
   localparam logic [1:0]       STOCK_INIT = 2'(STOCKS);
   localparam logic [9:0]       X_MAX      = 10'(BLAST_X_MAX);
   localparam logic [9:0]       Y_MAX      = 10'(BLAST_Y_MAX);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      FIGHT     = 3'd2,
      KO_PAUSE  = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       p1s_nx, p2s_nx, cd_nx, win_nx;
   logic [1:0]       ko_mask, ko_nx;
   logic             rs1_nx, rs2_nx;
   logic             ko1, ko2;
   logic [1:0]       s1_dec, s2_dec;

   function automatic logic [1:0] dec_sat(input logic [1:0] s, input logic hit);
      return (hit && s != 2'd0) ? s - 2'd1 : s;
   endfunction

   assign move_tick   = frame_rate && (state == FIGHT);
   assign round_state = state;

   // Left-edge exits wrap to large x, so a single upper bound catches both sides.
   assign ko1    = (p1_x > X_MAX) || (p1_y > Y_MAX);
   assign ko2    = (p2_x > X_MAX) || (p2_y > Y_MAX);
   assign s1_dec = dec_sat(p1_stocks, ko1);
   assign s2_dec = dec_sat(p2_stocks, ko2);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      p1s_nx   = p1_stocks;
      p2s_nx   = p2_stocks;
      cd_nx    = countdown;
      win_nx   = winner;
      ko_nx    = ko_mask;
      rs1_nx   = 1'b0;
      rs2_nx   = 1'b0;
      case (state)
         IDLE, GAME_OVER: begin
            if (start) begin
               state_nx = COUNTDOWN;
               cnt_nx   = SEC_LOAD;
               p1s_nx   = STOCK_INIT;
               p2s_nx   = STOCK_INIT;
               cd_nx    = 2'd3;
               win_nx   = 2'b00;
               ko_nx    = 2'b00;
               rs1_nx   = 1'b1;
               rs2_nx   = 1'b1;
            end
         end
         COUNTDOWN: begin
            if (frame_rate) begin
               if (cnt != '0) begin
                  cnt_nx = cnt - 1'b1;
               end else if (countdown > 2'd1) begin
                  cd_nx  = countdown - 2'd1;
                  cnt_nx = SEC_LOAD;
               end else begin
                  cd_nx    = 2'd0;
                  state_nx = FIGHT;
               end
            end
         end
         FIGHT: begin
            if (frame_rate && (ko1 || ko2)) begin
               p1s_nx = s1_dec;
               p2s_nx = s2_dec;
               if (s1_dec == 2'd0 && s2_dec == 2'd0) begin
`ifdef SUDDEN_DEATH_EN
                  p1s_nx   = 2'd1;
                  p2s_nx   = 2'd1;
                  cd_nx    = 2'd3;
                  cnt_nx   = SEC_LOAD;
                  rs1_nx   = 1'b1;
                  rs2_nx   = 1'b1;
                  state_nx = COUNTDOWN;
`else
                  win_nx   = 2'b11;
                  state_nx = GAME_OVER;
`endif
               end else if (s1_dec == 2'd0) begin
                  win_nx   = 2'b10;
                  state_nx = GAME_OVER;
               end else if (s2_dec == 2'd0) begin
                  win_nx   = 2'b01;
                  state_nx = GAME_OVER;
               end else begin
                  cnt_nx   = KO_LOAD;
                  ko_nx    = {ko2, ko1};
                  state_nx = KO_PAUSE;
               end
            end
         end
         KO_PAUSE: begin
            if (frame_rate) begin
               if (cnt != '0) begin
                  cnt_nx = cnt - 1'b1;
               end else begin
                  rs1_nx   = ko_mask[0];
                  rs2_nx   = ko_mask[1];
                  ko_nx    = 2'b00;
                  state_nx = FIGHT;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         p1_stocks  <= STOCK_INIT;
         p2_stocks  <= STOCK_INIT;
         countdown  <= 2'd0;
         winner     <= 2'b00;
         ko_mask    <= 2'b00;
         p1_respawn <= 1'b0;
         p2_respawn <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         p1_stocks  <= p1s_nx;
         p2_stocks  <= p2s_nx;
         countdown  <= cd_nx;
         winner     <= win_nx;
         ko_mask    <= ko_nx;
         p1_respawn <= rs1_nx;
         p2_respawn <= rs2_nx;
      end
   end

endmodule
